// File: rtl/calc_key_entry.sv
// -----------------------------------------------------------------------------
// calc_key_entry
//   Keypad front end of the calculator datapath. It turns single-cycle key
//   events into operand/operator state and issues requests to the arithmetic
//   stage. A request is held until that stage reports completion or the wait
//   times out. Returned results are loaded back into the operand registers,
//   which lets operations chain and lets results be displayed.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   key_valid      one-cycle strobe: key_in is valid
//   key_in         0-9 digit, 1010 add, 1011 sub, 1100 mul, 1101 div,
//                  1110 equals, 1111 clear
//   res_valid      completion flag from the arithmetic stage
//   res_a, res_b   returned operands (res_a carries the result)
//   res_dis_flag   returned entry phase
//   res_opera_flag returned operator
//   num_a, num_b   operands to the arithmetic stage
//   dis_flag       0 = entering A, 1 = entering B
//   opera_flag     latched operator
//   en             request valid to the arithmetic stage
//   key_num        operator code presented with en
//   digit_cnt      digits entered into the current operand
//   busy           high while waiting for a result
//   err            one-cycle error pulse
// -----------------------------------------------------------------------------
module calc_key_entry #(
    parameter int WIDTH      = 14,
    parameter int MAX_DIGITS = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_in,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_a,
    input  logic [WIDTH-1:0] res_b,
    input  logic             res_dis_flag,
    input  logic [3:0]       res_opera_flag,
    output logic [WIDTH-1:0] num_a,
    output logic [WIDTH-1:0] num_b,
    output logic             dis_flag,
    output logic [3:0]       opera_flag,
    output logic             en,
    output logic [3:0]       key_num,
    output logic [2:0]       digit_cnt,
    output logic             busy,
    output logic             err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] KEY_DIV = 4'b1101;
    localparam logic [3:0] KEY_EQ  = 4'b1110;
    localparam logic [3:0] KEY_CLR = 4'b1111;

    typedef enum logic [1:0] {ENTER_A, ENTER_B, WAIT_RES, RESULT} state_t;

    state_t          state, state_d, ret_state, ret_state_d;
    logic [WIDTH-1:0] num_a_d, num_b_d;
    logic            dis_flag_d, en_d, busy_d, err_d;
    logic [3:0]      opera_flag_d, key_num_d;
    logic [2:0]      digit_cnt_d;
    logic [TW-1:0]   tmo_cnt, tmo_cnt_d;

    logic             is_digit, is_op, is_eq, is_clr;
    logic [WIDTH-1:0] target;
    logic [WIDTH+3:0] acc;

    assign is_digit = (key_in <= 4'd9);
    assign is_op    = (key_in >= 4'b1010) && (key_in <= KEY_DIV);
    assign is_eq    = (key_in == KEY_EQ);
    assign is_clr   = (key_in == KEY_CLR);

    // Four spare bits make the shift-and-add overflow-free before truncation;
    // the digit limit keeps the true value within 9999 anyway.
    assign target = (state == ENTER_B) ? num_b : num_a;
    assign acc    = {4'b0, target} * (WIDTH+4)'(10) + (WIDTH+4)'(key_in);

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state;
        ret_state_d  = ret_state;
        num_a_d      = num_a;
        num_b_d      = num_b;
        dis_flag_d   = dis_flag;
        opera_flag_d = opera_flag;
        en_d         = en;
        key_num_d    = key_num;
        digit_cnt_d  = digit_cnt;
        tmo_cnt_d    = tmo_cnt;
        err_d        = 1'b0;

        if (key_valid && is_clr) begin
            state_d      = ENTER_A;
            ret_state_d  = ENTER_A;
            num_a_d      = '0;
            num_b_d      = '0;
            dis_flag_d   = 1'b0;
            opera_flag_d = '0;
            en_d         = 1'b0;
            key_num_d    = '0;
            digit_cnt_d  = '0;
            tmo_cnt_d    = '0;
        end else begin
            unique case (state)
                ENTER_A, ENTER_B: begin
                    if (key_valid && is_digit) begin
                        if (digit_cnt < 3'(MAX_DIGITS)) begin
                            if (state == ENTER_B) num_b_d = acc[WIDTH-1:0];
                            else                  num_a_d = acc[WIDTH-1:0];
                            digit_cnt_d = digit_cnt + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_valid && (is_op || is_eq)) begin
                        if (state == ENTER_A) begin
                            // Equals has nothing to complete while entering A.
                            if (is_op) begin
                                en_d        = 1'b1;
                                key_num_d   = key_in;
                                ret_state_d = state;
                                state_d     = WAIT_RES;
                                tmo_cnt_d   = '0;
                            end
                        end else if (opera_flag == KEY_DIV && num_b == '0) begin
                            err_d = 1'b1;
                        end else begin
                            // An operator here completes the pending operation
                            // and carries the new operator; equals re-sends the
                            // pending one.
                            en_d        = 1'b1;
                            key_num_d   = is_op ? key_in : opera_flag;
                            ret_state_d = state;
                            state_d     = WAIT_RES;
                            tmo_cnt_d   = '0;
                        end
                    end
                end

                RESULT: begin
                    if (key_valid && is_digit) begin
                        num_a_d      = WIDTH'(key_in);
                        num_b_d      = '0;
                        dis_flag_d   = 1'b0;
                        opera_flag_d = '0;
                        digit_cnt_d  = 3'd1;
                        state_d      = ENTER_A;
                    end else if (key_valid && is_op) begin
                        en_d        = 1'b1;
                        key_num_d   = key_in;
                        ret_state_d = state;
                        state_d     = WAIT_RES;
                        tmo_cnt_d   = '0;
                    end
                end

                WAIT_RES: begin
                    // Non-clear keys are dropped silently while a request is
                    // outstanding; a result beats a same-cycle timeout.
                    if (res_valid) begin
                        num_a_d      = res_a;
                        num_b_d      = res_b;
                        dis_flag_d   = res_dis_flag;
                        opera_flag_d = res_opera_flag;
                        en_d         = 1'b0;
                        digit_cnt_d  = '0;
                        state_d      = res_dis_flag ? ENTER_B : RESULT;
                    end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        en_d    = 1'b0;
                        err_d   = 1'b1;
                        state_d = ret_state;
                    end else begin
                        tmo_cnt_d = tmo_cnt + TW'(1);
                    end
                end

                default: state_d = ENTER_A;
            endcase
        end

        busy_d = (state_d == WAIT_RES);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ENTER_A;
            ret_state  <= ENTER_A;
            num_a      <= '0;
            num_b      <= '0;
            dis_flag   <= 1'b0;
            opera_flag <= '0;
            en         <= 1'b0;
            key_num    <= '0;
            digit_cnt  <= '0;
            tmo_cnt    <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            ret_state  <= ret_state_d;
            num_a      <= num_a_d;
            num_b      <= num_b_d;
            dis_flag   <= dis_flag_d;
            opera_flag <= opera_flag_d;
            en         <= en_d;
            key_num    <= key_num_d;
            digit_cnt  <= digit_cnt_d;
            tmo_cnt    <= tmo_cnt_d;
            busy       <= busy_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_calc_key_entry.sv
// -----------------------------------------------------------------------------
// tb_calc_key_entry
//   Directed self-checking bench for calc_key_entry. Every cycle step pushes
//   the hand-derived expected output snapshot to a queue as the stimulus is
//   driven. After the clock edge it pops that snapshot and compares it with
//   the registered outputs.
// -----------------------------------------------------------------------------
module tb_calc_key_entry;

    localparam int WIDTH   = 14;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             key_valid;
    logic [3:0]       key_in;
    logic             res_valid;
    logic [WIDTH-1:0] res_a, res_b;
    logic             res_dis_flag;
    logic [3:0]       res_opera_flag;
    logic [WIDTH-1:0] num_a, num_b;
    logic             dis_flag, en, busy, err;
    logic [3:0]       opera_flag, key_num;
    logic [2:0]       digit_cnt;

    typedef struct {
        logic [WIDTH-1:0] num_a;
        logic [WIDTH-1:0] num_b;
        logic             dis;
        logic [3:0]       opera;
        logic             en;
        logic [3:0]       key_num;
        logic [2:0]       cnt;
        logic             busy;
        logic             err;
    } exp_t;

    exp_t e;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    calc_key_entry #(.WIDTH(WIDTH), .MAX_DIGITS(4), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .key_valid      (key_valid),
        .key_in         (key_in),
        .res_valid      (res_valid),
        .res_a          (res_a),
        .res_b          (res_b),
        .res_dis_flag   (res_dis_flag),
        .res_opera_flag (res_opera_flag),
        .num_a          (num_a),
        .num_b          (num_b),
        .dis_flag       (dis_flag),
        .opera_flag     (opera_flag),
        .en             (en),
        .key_num        (key_num),
        .digit_cnt      (digit_cnt),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic clear_exp();
        e = '{default: '0};
    endtask

    // One clock step: drive inputs, queue the expectation, compare after edge.
    // err is a pulse, so the expectation drops it once it has been queued.
    task automatic cyc(input logic kv, input logic [3:0] k, input logic rv, input string tag);
        exp_t x;
        @(negedge clk);
        key_valid = kv;
        key_in    = k;
        res_valid = rv;
        sb.push_back(e);
        e.err = 1'b0;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            x = sb.pop_front();
            check({tag, ".num_a"},      32'(num_a),      32'(x.num_a));
            check({tag, ".num_b"},      32'(num_b),      32'(x.num_b));
            check({tag, ".dis_flag"},   32'(dis_flag),   32'(x.dis));
            check({tag, ".opera_flag"}, 32'(opera_flag), 32'(x.opera));
            check({tag, ".en"},         32'(en),         32'(x.en));
            check({tag, ".key_num"},    32'(key_num),    32'(x.key_num));
            check({tag, ".digit_cnt"},  32'(digit_cnt),  32'(x.cnt));
            check({tag, ".busy"},       32'(busy),       32'(x.busy));
            check({tag, ".err"},        32'(err),        32'(x.err));
        end
    endtask

    task automatic set_res(input int a, input int b, input logic dis, input logic [3:0] op);
        res_a          = WIDTH'(a);
        res_b          = WIDTH'(b);
        res_dis_flag   = dis;
        res_opera_flag = op;
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_in = '0; res_valid = 1'b0;
        set_res(0, 0, 1'b0, 4'd0);

        // Reset wins over a simultaneous key.
        clear_exp();
        cyc(1'b1, 4'd5, 1'b0, "reset");
        rst = 1'b0;

        // Keys 1,2,3 build 123.
        e.num_a = 1;   e.cnt = 1; cyc(1'b1, 4'd1, 1'b0, "dig1");
        e.num_a = 12;  e.cnt = 2; cyc(1'b1, 4'd2, 1'b0, "dig2");
        e.num_a = 123; e.cnt = 3; cyc(1'b1, 4'd3, 1'b0, "dig3");

        // Equals in ENTER_A is ignored.
        cyc(1'b1, 4'd14, 1'b0, "eq_in_a");

        // Clear, then four digits and a rejected fifth.
        clear_exp(); cyc(1'b1, 4'd15, 1'b0, "clr1");
        e.num_a = 5;    e.cnt = 1; cyc(1'b1, 4'd5, 1'b0, "d5");
        e.num_a = 56;   e.cnt = 2; cyc(1'b1, 4'd6, 1'b0, "d6");
        e.num_a = 567;  e.cnt = 3; cyc(1'b1, 4'd7, 1'b0, "d7");
        e.num_a = 5678; e.cnt = 4; cyc(1'b1, 4'd8, 1'b0, "d8");
        e.err = 1'b1;              cyc(1'b1, 4'd9, 1'b0, "d9_over");
        cyc(1'b0, 4'd0, 1'b0, "err_drop");

        // 12 + 3 = 15 through a full request/response round trip.
        clear_exp(); cyc(1'b1, 4'd15, 1'b0, "clr2");
        e.num_a = 1;  e.cnt = 1; cyc(1'b1, 4'd1, 1'b0, "a1");
        e.num_a = 12; e.cnt = 2; cyc(1'b1, 4'd2, 1'b0, "a2");
        e.en = 1'b1; e.key_num = 4'd10; e.busy = 1'b1;
        cyc(1'b1, 4'd10, 1'b0, "add_req");
        cyc(1'b0, 4'd0, 1'b0, "hold1");
        cyc(1'b1, 4'd3, 1'b0, "key_drop_wait");
        set_res(12, 0, 1'b1, 4'd10);
        e.en = 1'b0; e.busy = 1'b0; e.dis = 1'b1; e.opera = 4'd10; e.cnt = 0;
        cyc(1'b0, 4'd0, 1'b1, "res_to_b");
        e.num_b = 3; e.cnt = 1;  cyc(1'b1, 4'd3, 1'b0, "b3");
        e.en = 1'b1; e.key_num = 4'd10; e.busy = 1'b1;
        cyc(1'b1, 4'd14, 1'b0, "eq_req");
        set_res(15, 0, 1'b0, 4'd0);
        e.num_a = 15; e.num_b = 0; e.dis = 1'b0; e.opera = 4'd0;
        e.en = 1'b0; e.busy = 1'b0; e.cnt = 0;
        cyc(1'b0, 4'd0, 1'b1, "res_to_result");

        // RESULT: equals ignored, stray res_valid ignored, digit restarts A.
        cyc(1'b1, 4'd14, 1'b0, "eq_in_result");
        set_res(999, 7, 1'b1, 4'd12);
        cyc(1'b0, 4'd0, 1'b1, "res_outside_wait");
        e.num_a = 4; e.cnt = 1; cyc(1'b1, 4'd4, 1'b0, "result_digit");

        // Divide-by-zero guard.
        e.en = 1'b1; e.key_num = 4'd13; e.busy = 1'b1;
        cyc(1'b1, 4'd13, 1'b0, "div_req");
        set_res(4, 0, 1'b1, 4'd13);
        e.en = 1'b0; e.busy = 1'b0; e.dis = 1'b1; e.opera = 4'd13; e.cnt = 0;
        cyc(1'b0, 4'd0, 1'b1, "res_div_b");
        e.err = 1'b1; cyc(1'b1, 4'd14, 1'b0, "div0_eq");
        e.err = 1'b1; cyc(1'b1, 4'd10, 1'b0, "div0_op");
        cyc(1'b0, 4'd0, 1'b0, "div0_idle");
        e.num_b = 2; e.cnt = 1; cyc(1'b1, 4'd2, 1'b0, "b2");
        e.en = 1'b1; e.key_num = 4'd13; e.busy = 1'b1;
        cyc(1'b1, 4'd14, 1'b0, "div_ok_req");

        // Clear beats a same-cycle result.
        set_res(2, 0, 1'b1, 4'd11);
        clear_exp(); cyc(1'b1, 4'd15, 1'b1, "clr_vs_res");
        cyc(1'b0, 4'd0, 1'b0, "after_clr");

        // Timeout: en held for exactly TIMEOUT cycles, then err and return.
        e.num_a = 7; e.cnt = 1; cyc(1'b1, 4'd7, 1'b0, "t7");
        e.en = 1'b1; e.key_num = 4'd11; e.busy = 1'b1;
        cyc(1'b1, 4'd11, 1'b0, "sub_req");
        for (int i = 1; i < TIMEOUT; i++) cyc(1'b0, 4'd0, 1'b0, $sformatf("tmo_hold%0d", i));
        e.en = 1'b0; e.busy = 1'b0; e.err = 1'b1;
        cyc(1'b0, 4'd0, 1'b0, "tmo_expire");
        cyc(1'b0, 4'd0, 1'b0, "tmo_idle");
        e.num_a = 78; e.cnt = 2; cyc(1'b1, 4'd8, 1'b0, "tmo_back_in_a");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
